// File: rtl/bp_input_pkg.sv
// Shared scan codes, joystick bit indices and types for the BluePrint
// input conditioner.
package bp_input_pkg;

  localparam logic [7:0] SC_START1  = 8'h16;
  localparam logic [7:0] SC_START2  = 8'h1E;
  localparam logic [7:0] SC_COIN1   = 8'h2E;
  localparam logic [7:0] SC_COIN2   = 8'h36;
  localparam logic [7:0] SC_SERVICE = 8'h46;
  localparam logic [7:0] SC_PAUSE   = 8'h4D;
  localparam logic [7:0] SC_UP      = 8'h75;
  localparam logic [7:0] SC_DOWN    = 8'h72;
  localparam logic [7:0] SC_LEFT    = 8'h6B;
  localparam logic [7:0] SC_RIGHT   = 8'h74;
  localparam logic [7:0] SC_FIRE    = 8'h14;

  localparam int JB_R      = 0;
  localparam int JB_L      = 1;
  localparam int JB_D      = 2;
  localparam int JB_U      = 3;
  localparam int JB_FIRE   = 4;
  localparam int JB_START1 = 5;
  localparam int JB_COIN1  = 6;
  localparam int JB_START2 = 7;
  localparam int JB_PAUSE  = 8;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLDOFF
  } coin_state_t;

  typedef struct packed {
    logic start1;
    logic start2;
    logic coin1;
    logic coin2;
    logic service;
    logic pause;
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
  } keys_t;

endpackage

// File: rtl/bp_coin_pulse.sv
// One coin slot: edge-triggered, frame-timed credit pulse followed by
// a holdoff window. Counter saturates at 15.
module bp_coin_pulse
  import bp_input_pkg::*;
#(
  parameter int unsigned PULSE_FRAMES   = 4,
  parameter int unsigned HOLDOFF_FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin_raw,
  input  logic tick,
  input  logic pause,
  output logic coin_out
);

  localparam logic [3:0] PULSE_N = 4'(PULSE_FRAMES);
  localparam logic [3:0] HOLD_N  = 4'(HOLDOFF_FRAMES);

  coin_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic        prev_q;

  assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign coin_out = (state_q == PULSE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // pause freezes both state and counter
    if (!pause) begin
      unique case (state_q)
        IDLE: begin
          if (coin_raw && !prev_q) begin
            state_d = PULSE;
            cnt_d   = '0;
          end
        end
        PULSE: begin
          if (tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == PULSE_N) begin
              state_d = (HOLD_N == 4'd0) ? IDLE : HOLDOFF;
              cnt_d   = '0;
            end
          end
        end
        HOLDOFF: begin
          if (tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == HOLD_N) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= coin_raw;
    end
  end

endmodule

// File: rtl/bp_input_conditioner.sv
// Merges PS/2 keys and two HPS pads into BluePrint control bytes.
// Define SOCD_CLEAN_EN to cancel opposing directions per player.
module bp_input_conditioner
  import bp_input_pkg::*;
#(
  parameter int unsigned COIN_PULSE_FRAMES   = 4,
  parameter int unsigned COIN_HOLDOFF_FRAMES = 8
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        vblank,
  input  logic        pause,
  output logic [7:0]  p1_controls,
  output logic [7:0]  p2_controls,
  output logic        service,
  output logic        pause_btn
);

  logic       tog_q, primed_q, vblank_q;
  logic       ps2_evt, tick;
  keys_t      keys_q, keys_d;
  logic [7:0] p1_q, p1_d, p2_q, p2_d;
  logic       service_q, service_d;
  logic       pause_btn_q, pause_btn_d;
  logic       coin1_raw, coin2_raw;
  logic       coin1, coin2;
  logic       up1, down1, left1, right1;
  logic       up2, down2, left2, right2;
  logic       unused_bits;

  assign unused_bits = ^{ps2_key[8], joystick_0[15:9],
                         joystick_1[15:9]};

  // primed_q masks the first clock, when tog_q is still a reset value
  assign ps2_evt = primed_q && (ps2_key[10] != tog_q);
  assign tick    = vblank && !vblank_q;

  always_comb begin
    keys_d = keys_q;
    if (ps2_evt) begin
      unique case (1'b1)
        (ps2_key[7:0] == SC_START1):  keys_d.start1  = ps2_key[9];
        (ps2_key[7:0] == SC_START2):  keys_d.start2  = ps2_key[9];
        (ps2_key[7:0] == SC_COIN1):   keys_d.coin1   = ps2_key[9];
        (ps2_key[7:0] == SC_COIN2):   keys_d.coin2   = ps2_key[9];
        (ps2_key[7:0] == SC_SERVICE): keys_d.service = ps2_key[9];
        (ps2_key[7:0] == SC_PAUSE):   keys_d.pause   = ps2_key[9];
        (ps2_key[7:0] == SC_UP):      keys_d.up      = ps2_key[9];
        (ps2_key[7:0] == SC_DOWN):    keys_d.down    = ps2_key[9];
        (ps2_key[7:0] == SC_LEFT):    keys_d.left    = ps2_key[9];
        (ps2_key[7:0] == SC_RIGHT):   keys_d.right   = ps2_key[9];
        (ps2_key[7:0] == SC_FIRE):    keys_d.fire    = ps2_key[9];
        default: ;
      endcase
    end
  end

  assign coin1_raw = keys_q.coin1 | joystick_0[JB_COIN1]
                   | joystick_1[JB_COIN1];
  assign coin2_raw = keys_q.coin2;

  bp_coin_pulse #(
    .PULSE_FRAMES   (COIN_PULSE_FRAMES),
    .HOLDOFF_FRAMES (COIN_HOLDOFF_FRAMES)
  ) u_coin1 (
    .clk      (clk_49m),
    .rst_n    (reset),
    .coin_raw (coin1_raw),
    .tick     (tick),
    .pause    (pause),
    .coin_out (coin1)
  );

  bp_coin_pulse #(
    .PULSE_FRAMES   (COIN_PULSE_FRAMES),
    .HOLDOFF_FRAMES (COIN_HOLDOFF_FRAMES)
  ) u_coin2 (
    .clk      (clk_49m),
    .rst_n    (reset),
    .coin_raw (coin2_raw),
    .tick     (tick),
    .pause    (pause),
    .coin_out (coin2)
  );

  always_comb begin
    up1    = keys_q.up    | joystick_0[JB_U];
    down1  = keys_q.down  | joystick_0[JB_D];
    left1  = keys_q.left  | joystick_0[JB_L];
    right1 = keys_q.right | joystick_0[JB_R];
    up2    = keys_q.up    | joystick_1[JB_U];
    down2  = keys_q.down  | joystick_1[JB_D];
    left2  = keys_q.left  | joystick_1[JB_L];
    right2 = keys_q.right | joystick_1[JB_R];
`ifdef SOCD_CLEAN_EN
    if (left1 && right1) begin
      left1  = 1'b0;
      right1 = 1'b0;
    end
    if (up1 && down1) begin
      up1   = 1'b0;
      down1 = 1'b0;
    end
    if (left2 && right2) begin
      left2  = 1'b0;
      right2 = 1'b0;
    end
    if (up2 && down2) begin
      up2   = 1'b0;
      down2 = 1'b0;
    end
`endif
    p1_d = {
      coin1 | coin2,
      keys_q.start2 | joystick_0[JB_START2] | joystick_1[JB_START2],
      keys_q.start1 | joystick_0[JB_START1] | joystick_1[JB_START1],
      keys_q.fire | joystick_0[JB_FIRE],
      left1, down1, right1, up1
    };
    p2_d = {
      3'b111,
      keys_q.fire | joystick_1[JB_FIRE],
      left2, down2, right2, up2
    };
    service_d   = keys_q.service;
    pause_btn_d = keys_q.pause | joystick_0[JB_PAUSE]
                | joystick_1[JB_PAUSE];
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      tog_q       <= 1'b0;
      primed_q    <= 1'b0;
      vblank_q    <= 1'b1;
      keys_q      <= '0;
      p1_q        <= 8'h00;
      p2_q        <= 8'hE0;
      service_q   <= 1'b0;
      pause_btn_q <= 1'b0;
    end else begin
      tog_q       <= ps2_key[10];
      primed_q    <= 1'b1;
      vblank_q    <= vblank;
      keys_q      <= keys_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      service_q   <= service_d;
      pause_btn_q <= pause_btn_d;
    end
  end

  assign p1_controls = p1_q;
  assign p2_controls = p2_q;
  assign service     = service_q;
  assign pause_btn   = pause_btn_q;

endmodule

// File: tb/tb_bp_input_conditioner.sv
// Bench for bp_input_conditioner: level/key vectors via a scoreboard
// queue plus hand-written coin FSM sequences.
module tb_bp_input_conditioner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        vblank, pause;
  logic [7:0]  p1_controls, p2_controls;
  logic        service, pause_btn;

  int errors = 0;
  int checks = 0;

  bp_input_conditioner dut (
    .clk_49m     (clk),
    .reset       (rst_n),
    .ps2_key     (ps2_key),
    .joystick_0  (joystick_0),
    .joystick_1  (joystick_1),
    .vblank      (vblank),
    .pause       (pause),
    .p1_controls (p1_controls),
    .p2_controls (p2_controls),
    .service     (service),
    .pause_btn   (pause_btn)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] p1;
    logic [7:0] p2;
    logic       svc;
    logic       pb;
  } exp_t;

  typedef struct {
    logic [15:0] j0;
    logic [15:0] j1;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        pb;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];

  logic [7:0] e_p1 = 8'h00;
  logic [7:0] e_p2 = 8'hE0;
  logic       e_svc = 1'b0;
  logic       e_pb = 1'b0;

  task automatic push(input string nm, input logic [7:0] p1,
                      input logic [7:0] p2, input logic svc,
                      input logic pb);
    exp_t e;
    e.name = nm;
    e.p1 = p1;
    e.p2 = p2;
    e.svc = svc;
    e.pb = pb;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = sb.pop_front();
      if ({p1_controls, p2_controls, service, pause_btn} !==
          {e.p1, e.p2, e.svc, e.pb}) begin
        errors++;
        $display("FAIL %s: got p1=%h p2=%h svc=%b pb=%b required p1=%h p2=%h svc=%b pb=%b",
                 e.name, p1_controls, p2_controls, service, pause_btn,
                 e.p1, e.p2, e.svc, e.pb);
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vblank = 1'b1;
    clks(2);
    vblank = 1'b0;
    clks(4);
  endtask

  // count frames (out of n) after which the coin bit is high
  task automatic frames_high(input int n, output int hi);
    hi = 0;
    for (int f = 0; f < n; f++) begin
      frame();
      if (p1_controls[7]) hi++;
    end
  endtask

  task automatic key_evt(input string nm, input logic [7:0] code,
                         input logic pr, input logic [7:0] n_p1,
                         input logic [7:0] n_p2, input logic n_svc,
                         input logic n_pb);
    ps2_key = {~ps2_key[10], pr, 1'b0, code};
    push({nm, " +1clk"}, e_p1, e_p2, e_svc, e_pb);
    clks(1);
    pop_check();
    e_p1 = n_p1;
    e_p2 = n_p2;
    e_svc = n_svc;
    e_pb = n_pb;
    push({nm, " +2clk"}, e_p1, e_p2, e_svc, e_pb);
    clks(1);
    pop_check();
  endtask

  initial begin
    int hi;
    vecs[0]  = '{16'h0001, 16'h0000, 8'h02, 8'hE0, 1'b0};
    vecs[1]  = '{16'h0002, 16'h0000, 8'h08, 8'hE0, 1'b0};
    vecs[2]  = '{16'h0004, 16'h0000, 8'h04, 8'hE0, 1'b0};
    vecs[3]  = '{16'h0008, 16'h0000, 8'h01, 8'hE0, 1'b0};
    vecs[4]  = '{16'h0010, 16'h0000, 8'h10, 8'hE0, 1'b0};
    vecs[5]  = '{16'h0020, 16'h0000, 8'h20, 8'hE0, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0020, 8'h20, 8'hE0, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0080, 8'h40, 8'hE0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h000F, 8'h00, 8'hEF, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0010, 8'h00, 8'hF0, 1'b0};
    vecs[10] = '{16'h0100, 16'h0000, 8'h00, 8'hE0, 1'b1};
    vecs[11] = '{16'h0000, 16'h0100, 8'h00, 8'hE0, 1'b1};
`ifdef SOCD_CLEAN_EN
    vecs[12] = '{16'h0003, 16'h0000, 8'h00, 8'hE0, 1'b0};
    vecs[13] = '{16'h0000, 16'h000C, 8'h00, 8'hE0, 1'b0};
`else
    vecs[12] = '{16'h0003, 16'h0000, 8'h0A, 8'hE0, 1'b0};
    vecs[13] = '{16'h0000, 16'h000C, 8'h00, 8'hE5, 1'b0};
`endif

    // toggle bit high with a mapped pressed code: must not latch
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
    joystick_0 = '0;
    joystick_1 = '0;
    vblank = 1'b0;
    pause = 1'b0;
    clks(2);
    push("in reset", 8'h00, 8'hE0, 1'b0, 1'b0);
    pop_check();
    rst_n = 1'b1;
    push("reset release", 8'h00, 8'hE0, 1'b0, 1'b0);
    clks(4);
    pop_check();

    for (int i = 0; i < 14; i++) begin
      joystick_0 = vecs[i].j0;
      joystick_1 = vecs[i].j1;
      push($sformatf("vec%0d", i), vecs[i].p1, vecs[i].p2, 1'b0,
           vecs[i].pb);
      clks(1);
      pop_check();
    end
    joystick_0 = '0;
    joystick_1 = '0;
    clks(2);

    key_evt("key up",      8'h75, 1'b1, 8'h01, 8'hE1, 1'b0, 1'b0);
    key_evt("key up rel",  8'h75, 1'b0, 8'h00, 8'hE0, 1'b0, 1'b0);
    key_evt("key down",    8'h72, 1'b1, 8'h04, 8'hE4, 1'b0, 1'b0);
    key_evt("key left",    8'h6B, 1'b1, 8'h0C, 8'hEC, 1'b0, 1'b0);
    key_evt("key down rel",8'h72, 1'b0, 8'h08, 8'hE8, 1'b0, 1'b0);
    key_evt("key left rel",8'h6B, 1'b0, 8'h00, 8'hE0, 1'b0, 1'b0);
    key_evt("key right",   8'h74, 1'b1, 8'h02, 8'hE2, 1'b0, 1'b0);
    key_evt("key right rel",8'h74,1'b0, 8'h00, 8'hE0, 1'b0, 1'b0);
    key_evt("key fire",    8'h14, 1'b1, 8'h10, 8'hF0, 1'b0, 1'b0);
    key_evt("key fire rel",8'h14, 1'b0, 8'h00, 8'hE0, 1'b0, 1'b0);
    key_evt("key start1",  8'h16, 1'b1, 8'h20, 8'hE0, 1'b0, 1'b0);
    key_evt("key start2",  8'h1E, 1'b1, 8'h60, 8'hE0, 1'b0, 1'b0);
    key_evt("key st1 rel", 8'h16, 1'b0, 8'h40, 8'hE0, 1'b0, 1'b0);
    key_evt("key st2 rel", 8'h1E, 1'b0, 8'h00, 8'hE0, 1'b0, 1'b0);
    key_evt("key service", 8'h46, 1'b1, 8'h00, 8'hE0, 1'b1, 1'b0);
    key_evt("key svc rel", 8'h46, 1'b0, 8'h00, 8'hE0, 1'b0, 1'b0);
    key_evt("key pause",   8'h4D, 1'b1, 8'h00, 8'hE0, 1'b0, 1'b1);
    key_evt("key pause rel",8'h4D,1'b0, 8'h00, 8'hE0, 1'b0, 1'b0);
    key_evt("key unmapped",8'h5A, 1'b1, 8'h00, 8'hE0, 1'b0, 1'b0);

    // coin held for 100 frames: one 4-frame pulse only
    joystick_0[6] = 1'b1;
    clks(2);
    chk("coin held rise", int'(p1_controls[7]), 1);
    frame(); frame(); frame();
    chk("coin after 3 frames", int'(p1_controls[7]), 1);
    frame();
    chk("coin after 4 frames", int'(p1_controls[7]), 0);
    frames_high(96, hi);
    chk("coin held no retrigger", hi, 0);
    joystick_0[6] = 1'b0;
    clks(3);
    joystick_0[6] = 1'b1;
    clks(2);
    chk("coin second press", int'(p1_controls[7]), 1);
    frames_high(12, hi);
    chk("coin second pulse frames", hi, 3);
    joystick_0[6] = 1'b0;

    // press during holdoff is discarded
    clks(2);
    joystick_1[6] = 1'b1;
    clks(2);
    chk("ho rise", int'(p1_controls[7]), 1);
    frames_high(4, hi);
    chk("ho pulse frames", hi, 3);
    frame(); frame();
    joystick_1[6] = 1'b0;
    clks(2);
    joystick_1[6] = 1'b1;
    clks(2);
    chk("ho press ignored", int'(p1_controls[7]), 0);
    frames_high(6, hi);
    chk("ho rest of holdoff", hi, 0);
    clks(3);
    chk("ho held at idle", int'(p1_controls[7]), 0);
    joystick_1[6] = 1'b0;
    clks(2);
    joystick_1[6] = 1'b1;
    clks(2);
    chk("ho fresh edge", int'(p1_controls[7]), 1);
    joystick_1[6] = 1'b0;
    frames_high(12, hi);
    chk("ho fresh pulse frames", hi, 3);

    // pause mid-pulse freezes the coin FSM
    joystick_0[6] = 1'b1;
    clks(2);
    frame();
    pause = 1'b1;
    frames_high(10, hi);
    chk("paused coin high", hi, 10);
    pause = 1'b0;
    frame(); frame();
    chk("unpaused tick 3", int'(p1_controls[7]), 1);
    frame();
    chk("unpaused tick 4", int'(p1_controls[7]), 0);
    joystick_0[6] = 1'b0;
    frames_high(8, hi);

    // coin2 from keyboard shares p1 bit 7
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h36};
    clks(4);
    chk("coin2 key pulse", int'(p1_controls[7]), 1);
    ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h36};
    frames_high(4, hi);
    chk("coin2 pulse frames", hi, 3);
    frames_high(8, hi);

    // async reset mid-pulse, then no residual holdoff
    joystick_0[6] = 1'b1;
    clks(2);
    frame();
    chk("pre-reset coin", int'(p1_controls[7]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset coin", int'(p1_controls[7]), 0);
    chk("async reset p2", int'(p2_controls), 'hE0);
    joystick_0[6] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clks(3);
    joystick_0[6] = 1'b1;
    clks(2);
    chk("post-reset press", int'(p1_controls[7]), 1);
    frames_high(4, hi);
    chk("post-reset pulse frames", hi, 3);
    joystick_0[6] = 1'b0;
    clks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
